// File: rtl/ex_muldiv_stage.sv
// Execute-stage front end: operand forwarding, ALU source selection, and a
// multi-cycle multiply/divide unit with HI/LO registers and hazard stall.
module ex_muldiv_stage #(
  parameter int DATA_W     = 32,
  parameter int SHAMT_W    = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic               flush,
  input  logic [1:0]         forward_a,
  input  logic [1:0]         forward_b,
  input  logic [DATA_W-1:0]  reg_a,
  input  logic [DATA_W-1:0]  reg_b,
  input  logic [DATA_W-1:0]  fwd_exmem,
  input  logic [DATA_W-1:0]  fwd_memwb,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  imm,
  input  logic               alu_src1,
  input  logic               alu_src2,
  input  logic [2:0]         md_op,
  input  logic [1:0]         md_read,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [DATA_W-1:0]  ex_result,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo,
  output logic               busy,
  output logic               md_done,
  output logic               stall_req
);

  localparam int CNT_MAX = (MUL_CYCLES > DATA_W) ? MUL_CYCLES : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE = 2'b00, MUL = 2'b01, DIV = 2'b10} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   fa, fb;
  logic                issue, is_mul, is_div, div_signed;
  logic                cnt_last_mul, cnt_last_div;
  logic [DATA_W-1:0]   mul_a, mul_b;
  logic                mul_signed;
  logic [2*DATA_W-1:0] mul_ext_a, mul_ext_b, product;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W-1:0]   dvs, rem, quo, rem_next, quo_next, quo_fix, rem_fix;
  logic [DATA_W:0]     rem_shift, diff;
  logic                neg_q, neg_r;

  // Forwarding muxes and ALU operand selection
  always_comb begin
    case (forward_a)
      2'b00:   fa = reg_a;
      2'b01:   fa = fwd_memwb;
      2'b10:   fa = fwd_exmem;
      default: fa = '0;
    endcase
    case (forward_b)
      2'b00:   fb = reg_b;
      2'b01:   fb = fwd_memwb;
      2'b10:   fb = fwd_exmem;
      default: fb = '0;
    endcase
    alu_in1 = alu_src1 ? DATA_W'(shamt) : fa;
    alu_in2 = alu_src2 ? imm : fb;
  end

  // Hazard, issue and result selection
  always_comb begin
    busy       = (state != IDLE);
    stall_req  = valid_in & busy & ((md_op != 3'b000) | (md_read != 2'b00));
    issue      = valid_in & ~flush & ~stall_req;
    is_mul     = (md_op == OP_MULT) | (md_op == OP_MULTU);
    is_div     = (md_op == OP_DIV) | (md_op == OP_DIVU);
    div_signed = (md_op == OP_DIV);
    case (md_read)
      2'b01:   ex_result = hi;
      2'b10:   ex_result = lo;
      default: ex_result = alu_result;
    endcase
  end

  // Multiplier product and one restoring-divide step on magnitudes
  always_comb begin
    cnt_last_mul = (cnt == CNT_W'(MUL_CYCLES - 1));
    cnt_last_div = (cnt == CNT_W'(DATA_W - 1));
    mul_ext_a    = {{DATA_W{mul_signed & mul_a[DATA_W-1]}}, mul_a};
    mul_ext_b    = {{DATA_W{mul_signed & mul_b[DATA_W-1]}}, mul_b};
    product      = mul_ext_a * mul_ext_b;
    abs_a        = (div_signed & fa[DATA_W-1]) ? (~fa + 1'b1) : fa;
    abs_b        = (div_signed & fb[DATA_W-1]) ? (~fb + 1'b1) : fb;
    rem_shift    = {rem, quo[DATA_W-1]};
    diff         = rem_shift - {1'b0, dvs};
    rem_next     = diff[DATA_W] ? rem_shift[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_next     = {quo[DATA_W-2:0], ~diff[DATA_W]};
    quo_fix      = neg_q ? (~quo_next + 1'b1) : quo_next;
    rem_fix      = neg_r ? (~rem_next + 1'b1) : rem_next;
  end

  // Next-state logic; divide by zero never leaves IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue && is_mul) begin
          state_next = MUL;
        end else if (issue && is_div && (fb != '0)) begin
          state_next = DIV;
        end else begin
          state_next = IDLE;
        end
      end
      MUL:     state_next = cnt_last_mul ? IDLE : MUL;
      DIV:     state_next = cnt_last_div ? IDLE : DIV;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, iteration and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      md_done    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      dvs        <= '0;
      rem        <= '0;
      quo        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                mul_a      <= fa;
                mul_b      <= fb;
                mul_signed <= (md_op == OP_MULT);
                cnt        <= '0;
              end
              OP_DIV, OP_DIVU: begin
                if (fb == '0) begin
                  lo      <= '1;
                  hi      <= fa;
                  md_done <= 1'b1;
                end else begin
                  dvs   <= abs_b;
                  quo   <= abs_a;
                  rem   <= '0;
                  neg_q <= div_signed & (fa[DATA_W-1] ^ fb[DATA_W-1]);
                  neg_r <= div_signed & fa[DATA_W-1];
                  cnt   <= '0;
                end
              end
              OP_MTHI: hi <= fa;
              OP_MTLO: lo <= fa;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt_last_mul) begin
            {hi, lo} <= product;
            md_done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt_last_div) begin
            lo      <= quo_fix;
            hi      <= rem_fix;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Self-checking bench for ex_muldiv_stage: operand-mux vector table plus a
// scoreboard of expected HI/LO results for multiply/divide sequences.
module tb_ex_muldiv_stage;

  logic        clk = 1'b0;
  logic        reset, valid_in, flush, alu_src1, alu_src2;
  logic [1:0]  forward_a, forward_b, md_read;
  logic [31:0] reg_a, reg_b, fwd_exmem, fwd_memwb, imm, alu_result;
  logic [4:0]  shamt;
  logic [2:0]  md_op;
  logic [31:0] alu_in1, alu_in2, ex_result, hi, lo;
  logic        busy, md_done, stall_req;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  ex_muldiv_stage #(.DATA_W(32), .SHAMT_W(5), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b), .reg_a(reg_a), .reg_b(reg_b),
    .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb), .shamt(shamt), .imm(imm),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .md_op(md_op), .md_read(md_read),
    .alu_result(alu_result), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .ex_result(ex_result), .hi(hi), .lo(lo), .busy(busy), .md_done(md_done),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sa, sb;
    logic        s1, s2;
    logic [31:0] ra, rb, ex, mw, im;
    logic [4:0]  sh;
    logic [31:0] e1, e2;
  } mux_vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_md(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int ebusy, input string name);
    logic [63:0] e;
    int nbusy;
    bit done;
    reg_a = 32'hA5A5_0001; reg_b = 32'h5A5A_0002;
    fwd_exmem = 32'hEEEE_0003; fwd_memwb = 32'h7777_0004;
    case (sa)
      2'b01:   fwd_memwb = a;
      2'b10:   fwd_exmem = a;
      default: reg_a = a;
    endcase
    case (sb)
      2'b01:   fwd_memwb = b;
      2'b10:   fwd_exmem = b;
      default: reg_b = b;
    endcase
    forward_a = sa; forward_b = sb;
    alu_src1 = 1'b1; alu_src2 = 1'b1; shamt = 5'd9; imm = 32'h0000_0077;
    md_op = op; md_read = 2'b00; valid_in = 1'b1; flush = 1'b0;
    sb_q.push_back({ehi, elo});
    tick;
    valid_in = 1'b0; md_op = 3'b000;
    nbusy = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (md_done) begin
        e = sb_q.pop_front();
        check({name, " hi"}, {32'h0, hi}, {32'h0, e[63:32]});
        check({name, " lo"}, {32'h0, lo}, {32'h0, e[31:0]});
        m_hi = e[63:32]; m_lo = e[31:0];
        done = 1'b1;
      end else begin
        if (busy) begin
          nbusy++;
          check({name, " hold"}, {hi, lo}, {m_hi, m_lo});
        end
        tick;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: md_done never seen", name);
      void'(sb_q.pop_front());
    end
    check({name, " busy cycles"}, 64'(nbusy), 64'(ebusy));
  endtask

  mux_vec_t vecs[6];
  int n;

  initial begin
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; alu_src1 = 1'b0; alu_src2 = 1'b0;
    forward_a = 2'b00; forward_b = 2'b00; md_read = 2'b00; md_op = 3'b000;
    reg_a = '0; reg_b = '0; fwd_exmem = '0; fwd_memwb = '0; imm = '0;
    alu_result = 32'h0000_0055; shamt = '0;
    m_hi = '0; m_lo = '0;
    tick; tick;
    reset = 1'b0;
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset hi", {32'h0, hi}, 64'h0);
    check("reset lo", {32'h0, lo}, 64'h0);
    check("reset md_done", {63'h0, md_done}, 64'h0);
    check("reset stall", {63'h0, stall_req}, 64'h0);

    vecs[0] = '{2'b10, 2'b11, 1'b0, 1'b0, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'h00001234, 32'h50505050, 32'h0000_0099, 5'd3, 32'h00001234, 32'h00000000};
    vecs[1] = '{2'b10, 2'b00, 1'b1, 1'b0, 32'hA0A0A0A0, 32'h000055AA, 32'hE0E0E0E0, 32'h50505050, 32'h0000_0099, 5'd7, 32'h00000007, 32'h000055AA};
    vecs[2] = '{2'b00, 2'b01, 1'b0, 1'b0, 32'hCAFE0001, 32'hB0B0B0B0, 32'hE0E0E0E0, 32'h0BAD0002, 32'h0000_0099, 5'd1, 32'hCAFE0001, 32'h0BAD0002};
    vecs[3] = '{2'b01, 2'b10, 1'b0, 1'b0, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'h33334444, 32'h11112222, 32'h0000_0099, 5'd2, 32'h11112222, 32'h33334444};
    vecs[4] = '{2'b11, 2'b10, 1'b0, 1'b1, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'hE0E0E0E0, 32'h50505050, 32'hFFFF8000, 5'd4, 32'h00000000, 32'hFFFF8000};
    vecs[5] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'hE0E0E0E0, 32'h50505050, 32'h00000000, 5'd31, 32'h0000001F, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      forward_a = vecs[i].sa; forward_b = vecs[i].sb;
      alu_src1 = vecs[i].s1; alu_src2 = vecs[i].s2;
      reg_a = vecs[i].ra; reg_b = vecs[i].rb;
      fwd_exmem = vecs[i].ex; fwd_memwb = vecs[i].mw;
      imm = vecs[i].im; shamt = vecs[i].sh;
      #1;
      check($sformatf("mux[%0d] alu_in1", i), {32'h0, alu_in1}, {32'h0, vecs[i].e1});
      check($sformatf("mux[%0d] alu_in2", i), {32'h0, alu_in2}, {32'h0, vecs[i].e2});
    end
    tick;

    run_md(3'b001, 2'b00, 2'b00, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 4, "MULT");
    tick;
    check("md_done single pulse", {63'h0, md_done}, 64'h0);
    run_md(3'b010, 2'b00, 2'b00, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 4, "MULTU");
    run_md(3'b001, 2'b00, 2'b00, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 4, "MULT b2b");
    run_md(3'b011, 2'b00, 2'b00, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32, "DIV -7/2");
    run_md(3'b100, 2'b10, 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 32, "DIVU 100/7 fwd");
    run_md(3'b011, 2'b00, 2'b00, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 32, "DIV 7/-2");
    run_md(3'b011, 2'b00, 2'b00, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0, "DIV by 0");
    run_md(3'b011, 2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32, "DIV min/-1");
    tick;

    alu_result = 32'h0BEE_F00D;
    md_read = 2'b01; #1; check("ex_result hi", {32'h0, ex_result}, {32'h0, m_hi});
    md_read = 2'b10; #1; check("ex_result lo", {32'h0, ex_result}, {32'h0, m_lo});
    md_read = 2'b00; #1; check("ex_result alu", {32'h0, ex_result}, 64'h0BEE_F00D);
    md_read = 2'b11; #1; check("ex_result alu 11", {32'h0, ex_result}, 64'h0BEE_F00D);
    tick;

    // MFLO held in EX while a MULT is in flight
    forward_a = 2'b00; forward_b = 2'b00; reg_a = 32'h10; reg_b = 32'h20;
    md_read = 2'b00; md_op = 3'b001; valid_in = 1'b1;
    tick;
    md_op = 3'b000; md_read = 2'b10; alu_result = 32'hDEADBEEF;
    n = 0;
    for (int i = 0; i < 20 && stall_req; i++) begin
      n++;
      tick;
    end
    check("MFLO stall cycles", 64'(n), 64'd4);
    check("MFLO stall drop", {63'h0, stall_req}, 64'h0);
    check("MFLO md_done", {63'h0, md_done}, 64'h1);
    check("MFLO ex_result", {32'h0, ex_result}, 64'h200);
    check("MFLO hi", {32'h0, hi}, 64'h0);
    valid_in = 1'b0; md_read = 2'b00;
    m_hi = 32'h0; m_lo = 32'h200;
    tick;

    // MTHI/MTLO with and without flush
    md_op = 3'b101; reg_a = 32'hABCD; valid_in = 1'b1; flush = 1'b1;
    tick;
    check("MTHI flushed", {32'h0, hi}, {32'h0, m_hi});
    flush = 1'b0;
    tick;
    check("MTHI", {32'h0, hi}, 64'hABCD);
    md_op = 3'b110; reg_a = 32'h1357;
    tick;
    check("MTLO", {32'h0, lo}, 64'h1357);
    check("MTLO busy", {63'h0, busy}, 64'h0);
    valid_in = 1'b0; md_op = 3'b000;
    tick;

    // Reset in the middle of a divide
    reg_a = 32'd1000; reg_b = 32'd3; md_op = 3'b011; valid_in = 1'b1;
    tick;
    valid_in = 1'b0; md_op = 3'b000;
    for (int i = 0; i < 5; i++) tick;
    check("mid-DIV busy", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    tick;
    check("reset mid-DIV busy", {63'h0, busy}, 64'h0);
    check("reset mid-DIV hi", {32'h0, hi}, 64'h0);
    check("reset mid-DIV lo", {32'h0, lo}, 64'h0);
    check("reset mid-DIV md_done", {63'h0, md_done}, 64'h0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) n++;
      tick;
    end
    check("no md_done after reset", 64'(n), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Parametrised execute-stage front end for the five-stage pipeline.
- Performs operand forwarding and source selection for the existing combinational ALU.
- Adds a multi-cycle multiply/divide unit with architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO).
- Drives a stall request to the hazard unit while the unit is busy, and selects the final EX result.

Parameters:
DATA_W, 32, datapath width; must be even and >= 8
SHAMT_W, 5, shift-amount field width
MUL_CYCLES, 4, multiply busy cycles (>= 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_in  in  1  instruction in EX is valid
flush  in  1  squash the EX instruction this cycle
forward_a  in  2  00 reg_a, 01 fwd_memwb, 10 fwd_exmem, 11 zero
forward_b  in  2  same encoding for reg_b
reg_a  in  DATA_W  register-file operand A
reg_b  in  DATA_W  register-file operand B
fwd_exmem  in  DATA_W  EX/MEM result
fwd_memwb  in  DATA_W  MEM/WB result
shamt  in  SHAMT_W  shift amount
imm  in  DATA_W  extended immediate
alu_src1  in  1  1 selects zero-extended shamt for alu_in1
alu_src2  in  1  1 selects imm for alu_in2
md_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
md_read  in  2  00 ALU, 01 HI, 10 LO
alu_result  in  DATA_W  result from the external ALU
alu_in1  out  DATA_W  ALU operand 1
alu_in2  out  DATA_W  ALU operand 2
ex_result  out  DATA_W  final EX result
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
busy  out  1  mul/div in flight
md_done  out  1  one-cycle pulse when HI/LO commit
stall_req  out  1  hold IF/ID/EX this cycle

Behaviour:
- Forwarded operands fa/fb: combinational four-way mux per forward_a/forward_b; code 11 gives 0.
- alu_in1 = alu_src1 ? zero-extended shamt : fa.
- alu_in2 = alu_src2 ? imm : fb.
- Mul/div sources are always fa/fb and ignore alu_src1/alu_src2.
- Issue condition: valid_in & !flush & !stall_req. Only an issuing instruction starts an operation or writes HI/LO.
- FSM states:
  - IDLE: on issue of MULT/MULTU, latch operands and enter MUL. On issue of DIV/DIVU, latch operands and enter DIV.
  - MUL: counter runs MUL_CYCLES cycles. On the final edge, write {hi,lo} = full 2*DATA_W product (signed for MULT, unsigned for MULTU), pulse md_done, and return to IDLE.
  - DIV: restoring radix-2 on magnitudes, DATA_W cycles. On the final edge, write lo = quotient and hi = remainder, pulse md_done, and return to IDLE.
  - Signed divide: quotient sign = sign(a) XOR sign(b); remainder takes the sign of a.
  - Most-negative / -1: lo = 1 followed by DATA_W-1 zeros (0x80000000 at DATA_W=32), hi = 0.
- Divide by zero: no iteration. The next edge writes lo = all ones and hi = a, pulses md_done, and the FSM stays IDLE. busy is never asserted.
- busy = (state != IDLE).
- HI/LO are not observable until the commit edge; the hi/lo outputs keep their old values while busy.
- MTHI/MTLO on issue: hi (or lo) <= fa at the next edge; zero latency, busy not asserted.
- stall_req = valid_in & busy & (md_op != 000 | md_read != 00). It deasserts in the cycle after the commit edge, so the stalled MFHI/MFLO reads the new value.
- ex_result: 01 selects hi, 10 selects lo, 00 or 11 selects alu_result. Combinational from the current registers.
- flush:
  - Suppresses issue of the EX instruction.
  - Does not abort an operation already in flight, because its instruction has already left EX.
- reset (sync): state IDLE, counter 0, hi = lo = 0, busy = 0, md_done = 0. Any in-flight operation is discarded.
- Simultaneous events:
  - Commit edge coincides with an MTHI/MTLO attempt: the MTHI/MTLO is stalled that cycle, so no conflict arises.
  - Back-to-back MULT issues one cycle after the previous md_done.

Test Plan:
- forward_a=10, fwd_exmem=0x1234, alu_src1=0 -> alu_in1=0x1234. alu_src1=1, shamt=7 -> alu_in1=7. forward_b=11, alu_src2=0 -> alu_in2=0.
- MULT fa=0xFFFFFFFE, fb=3 -> busy for 4 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA, single md_done. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV fa=-7 (0xFFFFFFF9), fb=2 -> after 32 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- MFLO issued the cycle after MULT start -> stall_req high 4 cycles. Then ex_result equals the new lo and stall_req drops.
- DIV by 0 with fa=5 -> next cycle lo=0xFFFFFFFF, hi=5, busy never 1. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Reset asserted mid-DIV -> next cycle busy=0, hi=lo=0, no md_done. MTHI fa=0xABCD with flush=1 -> hi unchanged. MTHI without flush -> hi=0xABCD next cycle.
